seg_counter_multi: RTL and testbench

Multi-digit, parametrised up/down counter that drives multiplexed-free, per-digit seven-segment outputs.
- A prescaler divides clk_10MHz down to a configurable tick rate.
- Each tick steps a DIGITS-wide hex or BCD count, with ripple carry/borrow across digits.
- Adds enable, direction, synchronous load, a wrap flag, and registered segment outputs.
- Successor to the single-digit hex countdown display block; sits between board switches/buttons and the HEXn segment pins.

---
 rtl/seg_counter_multi.sv | 160 ++++++++++++++++
 tb/tb_seg_counter_multi.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_counter_multi.sv
// seg_counter_multi
//   Multi-digit up/down counter with per-digit seven-segment outputs.
//   A prescaler divides clk_10MHz down to TICK_HZ. Each tick steps the
//   DIGITS-wide hex (RADIX=16) or BCD (RADIX=10) count. Carry and borrow
//   ripple across all digits within a single cycle.
//
// Ports
//   clk_10MHz : system clock at CLK_HZ
//   rst       : asynchronous reset, active-high
//   en        : count enable; 0 freezes the prescaler and the count
//   up_dn     : 1 = count up, 0 = count down
//   load      : one-cycle synchronous load strobe
//   load_val  : value to load; digit i sits at [4i+3:4i]
//   count     : current count; digit 0 is least significant
//   tick      : one-cycle pulse at each prescaler terminal count
//   wrap      : one-cycle pulse when the whole count wraps around
//   seg       : {dp,g,f,e,d,c,b,a} per digit, active-low; digit i at [8i+7:8i]
module seg_counter_multi #(
   parameter int CLK_HZ  = 10_000_000,
   parameter int TICK_HZ = 1,
   parameter int DIGITS  = 4,
   parameter int RADIX   = 16,
   parameter logic [4*DIGITS-1:0] RESET_VAL = {DIGITS{4'(RADIX-1)}}
) (
   input  logic                  clk_10MHz,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  tick,
   output logic                  wrap,
   output logic [8*DIGITS-1:0]   seg
);

   localparam int P  = CLK_HZ / TICK_HZ;
   localparam int PW = (P < 2) ? 1 : $clog2(P);
   localparam logic [PW-1:0] P_LAST = PW'(P - 1);
   localparam logic [3:0]    D_MAX  = 4'(RADIX - 1);

   if (RADIX != 10 && RADIX != 16) begin : g_bad_radix
      $error("seg_counter_multi: RADIX must be 10 or 16");
   end
   if (P < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
      $error("seg_counter_multi: CLK_HZ/TICK_HZ must be an integer >= 2");
   end
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("seg_counter_multi: DIGITS must be 1..8");
   end

   // Active-low {dp,g..a} for a single digit; dp is always off.
   function automatic logic [7:0] seg_enc(input logic [3:0] d);
      logic [6:0] p;
      p = 7'h00;
      case (d)
         4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
         4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
         4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
         4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  4'hF: p = 7'h71;
         default: p = 7'h00;
      endcase
      return {1'b1, ~p};
   endfunction

   function automatic logic [8*DIGITS-1:0] seg_all(input logic [4*DIGITS-1:0] v);
      logic [8*DIGITS-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) r[8*i +: 8] = seg_enc(v[4*i +: 4]);
      return r;
   endfunction

   logic [PW-1:0]       psc;
   logic [4*DIGITS-1:0] nxt;
   logic [4*DIGITS-1:0] ld_fix;
   logic                cy_out;
   logic                step;

   // A step needs the tick and enable together; a load in the same cycle wins.
   assign step = tick & en & ~load;

   // Prescaler. A load restarts the tick period, so no tick is issued then.
   always_ff @(posedge clk_10MHz or posedge rst) begin
      if (rst) begin
         psc  <= '0;
         tick <= 1'b0;
      end else if (load) begin
         psc  <= '0;
         tick <= 1'b0;
      end else if (en) begin
         if (psc == P_LAST) begin
            psc  <= '0;
            tick <= 1'b1;
         end else begin
            psc  <= psc + PW'(1);
            tick <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

   // Next count: ripple carry/borrow through every digit combinationally.
   // Carry out of the top digit means the whole count wrapped.
   always_comb begin
      logic       cy;
      logic [3:0] d;
      nxt = count;
      cy  = 1'b1;
      d   = 4'h0;
      for (int i = 0; i < DIGITS; i++) begin
         d = count[4*i +: 4];
         if (cy) begin
            if (up_dn) begin
               if (d >= D_MAX) nxt[4*i +: 4] = 4'h0;
               else begin
                  nxt[4*i +: 4] = d + 4'h1;
                  cy = 1'b0;
               end
            end else begin
               if (d == 4'h0) nxt[4*i +: 4] = D_MAX;
               else begin
                  nxt[4*i +: 4] = d - 4'h1;
                  cy = 1'b0;
               end
            end
         end
      end
      cy_out = cy;
   end

   // In BCD mode a non-decimal digit loads as zero.
   always_comb begin
      ld_fix = load_val;
      for (int i = 0; i < DIGITS; i++) begin
         if (RADIX == 10 && load_val[4*i +: 4] > 4'd9) ld_fix[4*i +: 4] = 4'h0;
      end
   end

   always_ff @(posedge clk_10MHz or posedge rst) begin
      if (rst) begin
         count <= RESET_VAL;
         wrap  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (load) count <= ld_fix;
         else if (step) begin
            count <= nxt;
            wrap  <= cy_out;
         end
      end
   end

   // Registered decode: seg follows count one cycle later.
   always_ff @(posedge clk_10MHz or posedge rst) begin
      if (rst) seg <= seg_all(RESET_VAL);
      else     seg <= seg_all(count);
   end

endmodule

// File: tb/tb_seg_counter_multi.sv
module tb_seg_counter_multi;

   logic        clk_10MHz = 1'b0;
   logic        rst, en, up_dn, load;
   logic [11:0] lv;

   logic [7:0]  count_a;
   logic [15:0] seg_a;
   logic        tick_a, wrap_a;
   logic [11:0] count_b;
   logic [23:0] seg_b;
   logic        tick_b, wrap_b;

   int tests = 0;
   int fails = 0;

   always #5 clk_10MHz = ~clk_10MHz;

   seg_counter_multi #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .RADIX(16)) dut_a (
      .clk_10MHz(clk_10MHz), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_val(lv[7:0]), .count(count_a), .tick(tick_a), .wrap(wrap_a), .seg(seg_a));

   seg_counter_multi #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(3), .RADIX(10)) dut_b (
      .clk_10MHz(clk_10MHz), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_val(lv), .count(count_b), .tick(tick_b), .wrap(wrap_b), .seg(seg_b));

   // Active-high gfedcba patterns for 0..F.
   logic [6:0] pat_tbl [16];
   initial begin
      pat_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   end

   function automatic logic [23:0] seg_of(input logic [11:0] v, input int nd);
      logic [23:0] r;
      r = '0;
      for (int i = 0; i < nd; i++) r[8*i +: 8] = {1'b1, ~pat_tbl[v[4*i +: 4]]};
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Counts clock edges until tick is seen; expn is the expected edge count.
   task automatic wait_tick(input bit sel, input int expn, input string name);
      int n;
      bit got;
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(posedge clk_10MHz); #1;
         n++;
         got = sel ? tick_b : tick_a;
      end
      check(name, n, expn);
   endtask

   task automatic pulse_load(input logic [11:0] v);
      lv = v;
      load = 1'b1;
      @(posedge clk_10MHz); #1;
      load = 1'b0;
   endtask

   typedef struct {
      bit          sel;      // 0 = hex 2-digit, 1 = BCD 3-digit
      logic [11:0] lval;
      bit          up;
      logic [11:0] exp_ld;
      logic [11:0] exp_step;
      bit          exp_wrap;
   } vec_t;

   vec_t vecs [11];

   logic [11:0] c_now;
   logic [23:0] s_now;
   logic        w_now;
   bit          saw_tick;

   initial begin
      vecs = '{
         '{1'b0, 12'h000, 1'b0, 12'h000, 12'h0FF, 1'b1},
         '{1'b0, 12'h0FF, 1'b1, 12'h0FF, 12'h000, 1'b1},
         '{1'b0, 12'h03A, 1'b1, 12'h03A, 12'h03B, 1'b0},
         '{1'b0, 12'h040, 1'b0, 12'h040, 12'h03F, 1'b0},
         '{1'b0, 12'h00F, 1'b1, 12'h00F, 12'h010, 1'b0},
         '{1'b1, 12'h099, 1'b1, 12'h099, 12'h100, 1'b0},
         '{1'b1, 12'h999, 1'b1, 12'h999, 12'h000, 1'b1},
         '{1'b1, 12'h0A5, 1'b1, 12'h005, 12'h006, 1'b0},
         '{1'b1, 12'h000, 1'b0, 12'h000, 12'h999, 1'b1},
         '{1'b1, 12'h100, 1'b0, 12'h100, 12'h099, 1'b0},
         '{1'b1, 12'hFFF, 1'b1, 12'h000, 12'h001, 1'b0}
      };

      rst = 1'b1; en = 1'b1; up_dn = 1'b0; load = 1'b0; lv = '0;
      repeat (3) @(posedge clk_10MHz);
      #1;
      check("rst_count_a", {24'h0, count_a}, 32'h0FF);
      check("rst_count_b", {20'h0, count_b}, 32'h999);
      check("rst_tick",    {31'h0, tick_a},  32'h0);
      check("rst_wrap",    {31'h0, wrap_a},  32'h0);
      check("rst_seg_a",   {16'h0, seg_a},   {8'h0, seg_of(12'h0FF, 2)});
      check("rst_seg_b",   {8'h0, seg_b},    {8'h0, seg_of(12'h999, 3)});

      // First tick after reset release, then one down step.
      rst = 1'b0;
      wait_tick(1'b0, 10, "first_tick");
      @(posedge clk_10MHz); #1;
      check("first_step_a", {24'h0, count_a}, 32'h0FE);
      check("first_step_b", {20'h0, count_b}, 32'h998);
      check("tick_one_cycle", {31'h0, tick_a}, 32'h0);
      @(posedge clk_10MHz); #1;
      check("seg_d0_E", {24'h0, seg_a[7:0]}, 32'h86);
      check("seg_d1_F", {24'h0, seg_a[15:8]}, 32'h8E);

      // Load, step once, check wrap pulse width and decoded segments.
      for (int i = 0; i < 11; i++) begin
         up_dn = vecs[i].up;
         pulse_load(vecs[i].lval);
         c_now = vecs[i].sel ? count_b : {4'h0, count_a};
         check($sformatf("vec%0d_load", i), {20'h0, c_now}, {20'h0, vecs[i].exp_ld});
         wait_tick(vecs[i].sel, 10, $sformatf("vec%0d_tick", i));
         @(posedge clk_10MHz); #1;
         c_now = vecs[i].sel ? count_b : {4'h0, count_a};
         w_now = vecs[i].sel ? wrap_b : wrap_a;
         check($sformatf("vec%0d_step", i), {20'h0, c_now}, {20'h0, vecs[i].exp_step});
         check($sformatf("vec%0d_wrap", i), {31'h0, w_now}, {31'h0, vecs[i].exp_wrap});
         @(posedge clk_10MHz); #1;
         w_now = vecs[i].sel ? wrap_b : wrap_a;
         s_now = vecs[i].sel ? seg_b : {8'h0, seg_a};
         check($sformatf("vec%0d_wrap_end", i), {31'h0, w_now}, 32'h0);
         check($sformatf("vec%0d_seg", i), {8'h0, s_now},
               {8'h0, seg_of(vecs[i].exp_step, vecs[i].sel ? 3 : 2)});
      end

      // Enable pause with the prescaler sitting at 4.
      up_dn = 1'b1;
      pulse_load(12'h050);
      repeat (4) @(posedge clk_10MHz);
      #1;
      en = 1'b0;
      saw_tick = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk_10MHz); #1;
         if (tick_a) saw_tick = 1'b1;
      end
      check("pause_no_tick", {31'h0, saw_tick}, 32'h0);
      check("pause_count",   {24'h0, count_a}, 32'h050);
      en = 1'b1;
      wait_tick(1'b0, 6, "tick_after_pause");
      @(posedge clk_10MHz); #1;
      check("pause_step", {24'h0, count_a}, 32'h051);

      // Load landing in the same cycle as a tick.
      wait_tick(1'b0, 9, "tick_before_load");
      pulse_load(12'h03C);
      check("load_tick_count", {24'h0, count_a}, 32'h03C);
      check("load_tick_wrap",  {31'h0, wrap_a},  32'h0);
      wait_tick(1'b0, 10, "tick_after_load");
      check("load_tick_hold", {24'h0, count_a}, 32'h03C);
      @(posedge clk_10MHz); #1;
      check("load_tick_step", {24'h0, count_a}, 32'h03D);

      // Asynchronous reset between clock edges.
      @(posedge clk_10MHz); #3;
      rst = 1'b1;
      #1;
      check("arst_count_a", {24'h0, count_a}, 32'h0FF);
      check("arst_count_b", {20'h0, count_b}, 32'h999);
      check("arst_tick",    {31'h0, tick_a},  32'h0);
      check("arst_wrap",    {31'h0, wrap_a},  32'h0);
      check("arst_seg_a",   {16'h0, seg_a},   {8'h0, seg_of(12'h0FF, 2)});
      #2;
      rst = 1'b0;
      up_dn = 1'b0;
      wait_tick(1'b0, 10, "arst_first_tick");
      @(posedge clk_10MHz); #1;
      check("arst_step", {24'h0, count_a}, 32'h0FE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
